call_panel: RTL and testbench

- Front end that turns raw car and hall push-buttons into latched request vectors.
- Outputs floor/up/down drive the elevator controller's request inputs directly.
- Consumes the controller's floor_number/dir outputs to detect service, clear served calls and run a door dwell timer.
- Sits between the button I/O pads and the elevator controller.

---
 rtl/call_panel_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/call_panel.sv | 151 +++++++++++++++
 tb/tb_call_panel.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/call_panel_pkg.sv
// rtl/call_panel_pkg.sv - shared direction codes, FSM state type and floor-number helpers
package call_panel_pkg;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_DOWN = 2'b01;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    // floor_number is 1-based; 0 and anything above the top floor are bogus positions
    function automatic logic floor_valid(input logic [2:0] fn, input int n_floors);
        return (fn != 3'd0) && (int'(fn) <= n_floors);
    endfunction

    function automatic logic [2:0] floor_to_idx(input logic [2:0] fn);
        return fn - 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, saturating stable-high counter and one-cycle press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
        if (!r_sync2) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == CNT_MAX) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    // Pulse is aligned with the edge on which the debounced level rises, so the
    // request register latches on that same edge; saturation keeps it single-shot.
    assign o_press = (w_cnt_nxt == CNT_MAX) && (r_cnt != CNT_MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/call_panel.sv
// rtl/call_panel.sv - button-to-request latch, service clear and door dwell; CALL_CANCEL_EN enables car-call toggle cancel
module call_panel
    import call_panel_pkg::*;
#(
    parameter int N_FLOORS        = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DWELL_CYCLES    = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N_FLOORS-1:0] btn_car,
    input  logic [N_FLOORS-1:0] btn_up,
    input  logic [N_FLOORS-1:0] btn_down,
    input  logic [2:0]          floor_number,
    input  logic [1:0]          dir,
    output logic [N_FLOORS-1:0] floor,
    output logic [N_FLOORS-1:0] up,
    output logic [N_FLOORS-1:0] down,
    output logic                door_open,
    output logic                pos_err
);

    localparam int CW = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0]       DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [N_FLOORS-1:0] ONE        = N_FLOORS'(1);
    localparam logic [N_FLOORS-1:0] UP_MASK    = ~(ONE << (N_FLOORS - 1));
    localparam logic [N_FLOORS-1:0] DOWN_MASK  = ~ONE;

    logic [N_FLOORS-1:0] w_car_raw;
    logic [N_FLOORS-1:0] w_up_raw;
    logic [N_FLOORS-1:0] w_down_raw;
    logic [N_FLOORS-1:0] w_car_p;
    logic [N_FLOORS-1:0] w_up_p;
    logic [N_FLOORS-1:0] w_down_p;

    genvar gi;
    generate
        for (gi = 0; gi < N_FLOORS; gi++) begin : g_btn
            btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_car (
                .clock   (clock),
                .reset_n (reset_n),
                .i_btn   (btn_car[gi]),
                .o_press (w_car_raw[gi])
            );
            btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
                .clock   (clock),
                .reset_n (reset_n),
                .i_btn   (btn_up[gi]),
                .o_press (w_up_raw[gi])
            );
            btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
                .clock   (clock),
                .reset_n (reset_n),
                .i_btn   (btn_down[gi]),
                .o_press (w_down_raw[gi])
            );
        end
    endgenerate

    // No up call exists at the top floor and no down call at the bottom floor.
    assign w_car_p  = w_car_raw;
    assign w_up_p   = w_up_raw & UP_MASK;
    assign w_down_p = w_down_raw & DOWN_MASK;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [N_FLOORS-1:0] r_floor;
    logic [N_FLOORS-1:0] r_up;
    logic [N_FLOORS-1:0] r_down;
    logic                r_pos_err;

    logic                w_dir_idle;
    logic                w_valid;
    logic [N_FLOORS-1:0] w_k_onehot;
    logic                w_pending_k;
    logic                w_press_k;
    state_t              w_state_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [N_FLOORS-1:0] w_clr;
    logic [N_FLOORS-1:0] w_floor_set;

    assign w_dir_idle  = (dir == DIR_IDLE);
    assign w_valid     = floor_valid(floor_number, N_FLOORS);
    assign w_k_onehot  = w_valid ? (ONE << floor_to_idx(floor_number)) : '0;
    assign w_pending_k = |((r_floor | r_up | r_down) & w_k_onehot);
    assign w_press_k   = |((w_car_p | w_up_p | w_down_p) & w_k_onehot);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr       = '0;
        case (r_state)
            IDLE: begin
                if (w_dir_idle && w_pending_k) begin
                    w_state_nxt = DWELL;
                    w_cnt_nxt   = DWELL_LOAD;
                    w_clr       = w_k_onehot;
                end
            end
            DWELL: begin
                if (!w_dir_idle || !w_valid) begin
                    w_state_nxt = IDLE;
                end else begin
                    // Door is open here: presses at this floor are swallowed and re-open the door.
                    w_clr = w_k_onehot;
                    if (w_press_k) begin
                        w_cnt_nxt = DWELL_LOAD;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef CALL_CANCEL_EN
    assign w_floor_set = r_floor ^ w_car_p;
`else
    assign w_floor_set = r_floor | w_car_p;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_floor   <= '0;
            r_up      <= '0;
            r_down    <= '0;
            r_pos_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_floor <= w_floor_set & ~w_clr;
            r_up    <= (r_up | w_up_p) & ~w_clr & UP_MASK;
            r_down  <= (r_down | w_down_p) & ~w_clr & DOWN_MASK;
            if (w_dir_idle && !w_valid) begin
                r_pos_err <= 1'b1;
            end
        end
    end

    assign floor     = r_floor;
    assign up        = r_up;
    assign down      = r_down;
    assign door_open = (r_state == DWELL);
    assign pos_err   = r_pos_err;

endmodule

// File: tb/tb_call_panel.sv
// tb/tb_call_panel.sv - directed plus randomized bench for call_panel against a cycle-level reference model
module tb_call_panel;

    localparam int N  = 5;
    localparam int DB = 4;
    localparam int DW = 8;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [N-1:0] btn_car, btn_up, btn_down;
    logic [2:0]   floor_number;
    logic [1:0]   dir;
    logic [N-1:0] floor, up, down;
    logic         door_open, pos_err;

    call_panel #(.N_FLOORS(N), .DEBOUNCE_CYCLES(DB), .DWELL_CYCLES(DW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .btn_car      (btn_car),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .floor_number (floor_number),
        .dir          (dir),
        .floor        (floor),
        .up           (up),
        .down         (down),
        .door_open    (door_open),
        .pos_err      (pos_err)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw sample history per button (bit j = sample taken j+1 edges ago),
    // pending calls as vectors, door as "cycles left open".
    logic [31:0]  hist [3*N];
    logic [N-1:0] m_floor, m_up, m_down;
    bit           m_door;
    int           m_rem;
    bit           m_perr;

    task automatic model_reset();
        for (int b = 0; b < 3*N; b++) hist[b] = '0;
        m_floor = '0; m_up = '0; m_down = '0;
        m_door = 0; m_rem = 0; m_perr = 0;
    endtask

    // A press registers on the edge where the button has been sampled high for DB
    // consecutive edges ending two edges ago, after having been low just before that run.
    function automatic bit pressed(input logic [31:0] h);
        bit all_high = 1'b1;
        for (int j = 1; j <= DB; j++) if (!h[j]) all_high = 1'b0;
        return all_high && !h[DB+1];
    endfunction

    task automatic model_edge();
        logic [N-1:0] pc, pu, pd;
        bit kv, idle, clr;
        int k;
        for (int i = 0; i < N; i++) begin
            pc[i] = pressed(hist[i]);
            pu[i] = pressed(hist[N+i]) && (i != N-1);
            pd[i] = pressed(hist[2*N+i]) && (i != 0);
        end
        for (int i = 0; i < N; i++) begin
            hist[i]     = {hist[i][30:0], btn_car[i]};
            hist[N+i]   = {hist[N+i][30:0], btn_up[i]};
            hist[2*N+i] = {hist[2*N+i][30:0], btn_down[i]};
        end
        kv   = (floor_number >= 1) && (floor_number <= N);
        k    = kv ? int'(floor_number) - 1 : 0;
        idle = (dir == 2'b00);
        clr  = 0;
        if (!m_door) begin
            if (idle && kv && (m_floor[k] || m_up[k] || m_down[k])) begin
                m_door = 1; m_rem = DW; clr = 1;
            end
        end else if (!idle || !kv) begin
            m_door = 0; m_rem = 0;
        end else begin
            clr = 1;
            if (pc[k] || pu[k] || pd[k]) m_rem = DW;
            else begin
                m_rem--;
                if (m_rem == 0) m_door = 0;
            end
        end
`ifdef CALL_CANCEL_EN
        m_floor = m_floor ^ pc;
`else
        m_floor = m_floor | pc;
`endif
        m_up   = m_up | pu;
        m_down = m_down | pd;
        if (clr) begin
            m_floor[k] = 1'b0; m_up[k] = 1'b0; m_down[k] = 1'b0;
        end
        if (idle && !kv) m_perr = 1;
    endtask

    task automatic check_outputs();
        check("floor", 32'(floor), 32'(m_floor));
        check("up", 32'(up), 32'(m_up));
        check("down", 32'(down), 32'(m_down));
        check("door_open", 32'(door_open), 32'(m_door));
        check("pos_err", 32'(pos_err), 32'(m_perr));
    endtask

    task automatic cycle();
        @(posedge clock);
        if (reset_n) model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    initial begin
        reset_n = 1'b0;
        btn_car = '0; btn_up = '0; btn_down = '0;
        floor_number = 3'd1; dir = 2'b10;
        model_reset();
        repeat (3) cycle();
        check("rst_state", 32'({floor, up, down, door_open, pos_err}), 32'd0);
        reset_n = 1'b1;

        // Car call latency and single latch on a long hold
        btn_car[3] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cycle();
            check("t1_latency", 32'(floor), (c >= 6) ? 32'd8 : 32'd0);
        end
        btn_car[3] = 1'b0;
        repeat (4) cycle();
        check("t1_once", 32'(floor), 32'd8);

        // Three-cycle glitch is rejected
        btn_up[2] = 1'b1;
        repeat (3) cycle();
        btn_up[2] = 1'b0;
        repeat (6) cycle();
        check("t2_glitch", 32'(up), 32'd0);

        // Serve floor 3 with up[2] and floor[2] pending; door open exactly DW cycles
        btn_up[2] = 1'b1; btn_car[2] = 1'b1;
        repeat (8) cycle();
        btn_up[2] = 1'b0; btn_car[2] = 1'b0;
        repeat (2) cycle();
        check("t3_pending", 32'({floor, up}), 32'({5'b01100, 5'b00100}));
        floor_number = 3'd3; dir = 2'b00;
        for (int c = 1; c <= 9; c++) begin
            cycle();
            check("t3_door", 32'(door_open), (c <= DW) ? 32'd1 : 32'd0);
            if (c == 1) check("t3_clear", 32'({floor, up}), 32'({5'b01000, 5'b00000}));
        end

        // Press at the open floor restarts dwell; press elsewhere latches
        dir = 2'b10;
        btn_car[2] = 1'b1;
        repeat (7) cycle();
        btn_car[2] = 1'b0;
        cycle();
        dir = 2'b00;
        btn_down[2] = 1'b1; btn_car[4] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            cycle();
            if (c == 8) begin
                btn_down[2] = 1'b0; btn_car[4] = 1'b0;
            end
            if (c == 12) check("t4_restart", 32'(door_open), 32'd1);
        end
        check("t4_closed", 32'(door_open), 32'd0);
        check("t4_down", 32'(down), 32'd0);
        check("t4_floor", 32'(floor), 32'b11000);

        // Non-existent hall calls, then bogus position while idle
        dir = 2'b10;
        btn_up[4] = 1'b1; btn_down[0] = 1'b1;
        repeat (8) cycle();
        btn_up[4] = 1'b0; btn_down[0] = 1'b0;
        repeat (3) cycle();
        check("t5_edges", 32'({up, down}), 32'd0);
        floor_number = 3'd0; dir = 2'b00;
        cycle();
        check("t5_pos_err", 32'(pos_err), 32'd1);
        check("t5_noclear", 32'(floor), 32'b11000);

        // Reset in the middle of a dwell
        floor_number = 3'd4;
        repeat (3) cycle();
        check("t6_dwell", 32'({door_open, floor}), 32'b110000);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check("t6_async", 32'({floor, up, down, door_open, pos_err}), 32'd0);
        cycle();
        reset_n = 1'b1;

`ifdef CALL_CANCEL_EN
        dir = 2'b10; floor_number = 3'd1;
        for (int p = 0; p < 2; p++) begin
            btn_car[1] = 1'b1;
            repeat (8) cycle();
            btn_car[1] = 1'b0;
            repeat (4) cycle();
            check("t7_cancel", 32'(floor[1]), (p == 0) ? 32'd1 : 32'd0);
        end
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) btn_car[i]  = ~btn_car[i];
                if ($urandom_range(0, 15) == 0) btn_up[i]   = ~btn_up[i];
                if ($urandom_range(0, 15) == 0) btn_down[i] = ~btn_down[i];
            end
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 5))
                    0, 1, 2: dir = 2'b00;
                    3:       dir = 2'b10;
                    4:       dir = 2'b01;
                    default: dir = 2'b11;
                endcase
            end
            if ($urandom_range(0, 7) == 0) begin
                int r;
                r = $urandom_range(0, 19);
                if (r < 17)       floor_number = 3'(1 + r % N);
                else if (r == 17) floor_number = 3'd0;
                else              floor_number = 3'(6 + (r - 18));
            end
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                model_reset();
                repeat (2) cycle();
                reset_n = 1'b1;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
